mux_stream_arbiter: RTL

Two-input round-robin stream arbiter that sits directly upstream of the 2:1 mux datapath. It chooses which of two valid/ready sources may send, registers the winning word, and presents the word together with a registered select bit. The select bit is the same S a downstream mux consumes, so `out_data` and `out_sel` always refer to the same transfer. A burst limit prevents one source from starving the other.

---
 rtl/mux_stream_arbiter_pkg.sv | 18 +
 rtl/mux_stream_arbiter_mux2.sv | 13 +
 rtl/mux_stream_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/mux_stream_arbiter_pkg.sv
// Shared definitions for the two-source round-robin stream arbiter.
// Grant state encodings and burst counter width.
package mux_stream_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // Grant state of the source that is not currently granted.
    function automatic arb_state_t other_grant(input arb_state_t s);
        return (s == GRANT1) ? GRANT0 : GRANT1;
    endfunction

endpackage

// File: rtl/mux_stream_arbiter_mux2.sv
// WIDTH-bit 2:1 data mux steered by the arbiter grant.
module stream_mux2 #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0_data,
    input  logic [WIDTH-1:0] in1_data,
    output logic [WIDTH-1:0] out_data
);

    assign out_data = sel ? in1_data : in0_data;

endmodule

// File: rtl/mux_stream_arbiter.sv
// Two-input round-robin valid/ready arbiter with a burst limit; registers the
// winning word together with the select bit the downstream mux consumes.
module mux_stream_arbiter
    import mux_stream_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             last;
    logic             space, sel, xfer;
    logic             own_valid, oth_valid;
    logic [WIDTH-1:0] mux_data;

    // Ready depends only on grant and output slot, never on the source valid.
    assign space     = !out_valid || out_ready;
    assign in0_ready = (state == GRANT0) && space;
    assign in1_ready = (state == GRANT1) && space;
    assign sel       = (state == GRANT1);
    assign xfer      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
    assign own_valid = sel ? in1_valid : in0_valid;
    assign oth_valid = sel ? in0_valid : in1_valid;

    stream_mux2 #(.WIDTH(WIDTH)) u_mux (
        .sel      (sel),
        .in0_data (in0_data),
        .in1_data (in1_data),
        .out_data (mux_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                count_nxt = '0;
                if (in0_valid && in1_valid) state_nxt = last ? GRANT0 : GRANT1;
                else if (in0_valid)         state_nxt = GRANT0;
                else if (in1_valid)         state_nxt = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (!own_valid) begin
                    count_nxt = '0;
                    state_nxt = oth_valid ? other_grant(state) : IDLE;
                end else if (xfer) begin
                    // Burst limit: hand over without a bubble if the other side waits.
                    if (count == CNT_MAX) begin
                        count_nxt = '0;
                        if (oth_valid) state_nxt = other_grant(state);
                    end else begin
                        count_nxt = count + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
            last      <= 1'b1;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_sel   <= sel;
            last      <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
